xy_datamux_pipe: RTL and testbench
==================================

XY_DATAMUX_PIPE -- requirements
Module: xy_datamux_pipe

Interface
REQ-001 Parameter W, default 16, width of one X or Y half-word (4..32).
REQ-002 Parameter NCH, default 2, number of independent X/Y register channels (1..4).
REQ-003 Parameter SAT, default 0; 0 = ADDQ results wrap modulo 2^W, 1 = ADDQ results saturate as signed two's-complement.
REQ-004 sys_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 gpu_din  in  2W  GPU write data; low-order W bits = X half, high-order W bits = Y half.
REQ-007 gpu_wr  in  1  GPU load strobe, one cycle per write.
REQ-008 gpu_ch  in  max(1,clog2(NCH))  channel targeted by gpu_wr.
REQ-009 addq_req  in  1  ADDQ increment request, held until acknowledged.
REQ-010 addq_ch  in  max(1,clog2(NCH))  channel targeted by the ADDQ request.
REQ-011 addq_x, addq_y  in  W each  signed increments for X and Y.
REQ-012 addq_ack  out  1  combinational; request accepted at the coming edge.
REQ-013 data_x, data_y  out  NCH*W each  registered X/Y per channel; channel n in bits [n*W +: W].
REQ-014 upd  out  NCH  one-cycle pulse per channel whose X/Y registers changed at the previous edge.
REQ-015 busy  out  1  ADDQ pipeline stage occupied.

Function
REQ-016 Each channel SHALL hold one W-bit X register and one W-bit Y register driving data_x/data_y directly (no combinational path from any input).
REQ-017 gpu_wr=1 SHALL load X and Y of channel gpu_ch from gpu_din at that edge; visible the following cycle; upd[gpu_ch]=1 that following cycle.
REQ-018 gpu_ch or addq_ch >= NCH SHALL be ignored (no register change, no upd, no ack).
REQ-019 addq_ack SHALL equal addq_req & ~gpu_wr & (addq_ch < NCH); GPU writes always take priority at acceptance.
REQ-020 On acceptance, stage 1 SHALL capture addq_ch, addq_x, addq_y and set busy=1 for the next cycle.
REQ-021 At the edge after acceptance, stage 2 SHALL write X <= X + addq_x and Y <= Y + addq_y for the captured channel, reading register values current at that edge; upd pulses the cycle after.
REQ-022 Latency: request accepted at edge N -> new data_x/data_y visible after edge N+1.
REQ-023 Back-to-back ADDQs (one accepted per cycle) SHALL be supported, including to the same channel; each increment applied exactly once, in order; busy stays 1 while stage 1 holds a valid entry.
REQ-024 SAT=0: sums truncated to W bits (wrap). SAT=1: sums computed in W+1 bits and clamped to [-2^(W-1), 2^(W-1)-1], independently for X and Y.
REQ-025 gpu_wr to the same channel at the same edge as a stage-2 writeback: GPU data SHALL win; the pending increment is discarded; upd pulses once.
REQ-026 gpu_wr to a different channel at a stage-2 writeback edge: both updates SHALL occur; both upd bits pulse.
REQ-027 addq_req deasserted while stage 1 valid SHALL not affect the in-flight increment.

Reset
REQ-028 reset=1 at an edge SHALL clear all X/Y registers to 0, clear stage-1 valid, and force upd=0, busy=0 the following cycle.
REQ-029 While reset=1, addq_ack SHALL be 0 and gpu_wr SHALL be ignored; reset mid-operation discards any in-flight increment.

Verification
REQ-030 W=16, NCH=2: gpu_wr ch1 gpu_din=0x00300010 -> next cycle ch1 X=0x0010, Y=0x0030, upd=2'b10; ch0 unchanged at 0.
REQ-031 ch0 X=0x0005; ADDQ ch0 x=+3 accepted at edge N -> X=0x0008 after edge N+1; busy=1 for one cycle; upd[0] pulse.
REQ-032 Three consecutive ADDQs ch0 x=+1 with X=0 -> X=1,2,3 on successive cycles; addq_ack high all three cycles.
REQ-033 ch0 X=0x7FFE, ADDQ x=+4: SAT=0 -> 0x8002; SAT=1 -> 0x7FFF; X=0x8001, ADDQ x=-4, SAT=1 -> 0x8000.
REQ-034 ADDQ ch0 accepted, next cycle gpu_wr ch0 data 0x00000100 -> X=0x0100, Y=0 (increment dropped), single upd pulse; same with gpu_wr to ch1 -> both channels update.
REQ-035 reset asserted the cycle after an ADDQ acceptance -> all registers 0, busy=0, upd=0, no increment applied.

Source files
------------

// File: rtl/xy_datamux_pipe.sv
// xy_datamux_pipe: NCH independent X/Y register channels. Each channel can be loaded
// directly by the GPU or incremented through a two-stage ADDQ pipeline. Increments
// either wrap or saturate, as selected by the SAT parameter.
//
// Ports:
//   sys_clk, reset       single clock; synchronous active-high reset
//   gpu_din/gpu_wr/gpu_ch GPU load: X = gpu_din[W-1:0], Y = gpu_din[2W-1:W]
//   addq_req/ch/x/y      increment request, held by the requester until addq_ack
//   addq_ack             combinational; the request is taken at the coming edge
//   data_x/data_y        registered X/Y, channel n in bits [n*W +: W]
//   upd                  one-cycle pulse for each channel written at the previous edge
//   busy                 stage 1 holds an accepted increment
module xy_datamux_pipe #(
  parameter int unsigned W   = 16,
  parameter int unsigned NCH = 2,
  parameter bit          SAT = 1'b0
) (
  input  logic                                 sys_clk,
  input  logic                                 reset,
  input  logic [2*W-1:0]                       gpu_din,
  input  logic                                 gpu_wr,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] gpu_ch,
  input  logic                                 addq_req,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] addq_ch,
  input  logic [W-1:0]                         addq_x,
  input  logic [W-1:0]                         addq_y,
  output logic                                 addq_ack,
  output logic [NCH*W-1:0]                     data_x,
  output logic [NCH*W-1:0]                     data_y,
  output logic [NCH-1:0]                       upd,
  output logic                                 busy
);

  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  // Signed add in W+1 bits; on overflow the extra sign bit picks the clamp direction.
  function automatic logic [W-1:0] add_w(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (SAT && (s[W] != s[W-1])) begin
      add_w = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      add_w = s[W-1:0];
    end
  endfunction

  logic [NCH*W-1:0] x_q, x_d, y_q, y_d;
  logic [NCH-1:0]   upd_q, upd_d;
  logic             s1_vld_q, s1_vld_d;
  logic [CW-1:0]    s1_ch_q, s1_ch_d;
  logic [W-1:0]     s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic             addq_ch_ok;

  assign addq_ch_ok = (32'(addq_ch) < NCH);
  assign addq_ack   = addq_req & ~gpu_wr & ~reset & addq_ch_ok;

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    upd_d    = '0;
    s1_vld_d = addq_ack;
    s1_ch_d  = addq_ch;
    s1_x_d   = addq_x;
    s1_y_d   = addq_y;
    for (int unsigned n = 0; n < NCH; n++) begin
      // Writeback reads the registers as they stand at this edge, so back-to-back
      // increments to one channel chain through the previous result.
      if (s1_vld_q && (s1_ch_q == CW'(n))) begin
        x_d[n*W +: W] = add_w(x_q[n*W +: W], s1_x_q);
        y_d[n*W +: W] = add_w(y_q[n*W +: W], s1_y_q);
        upd_d[n]      = 1'b1;
      end
      // GPU load is applied last so it overrides a same-channel writeback.
      // Channel codes >= NCH match no n and are dropped.
      if (gpu_wr && (gpu_ch == CW'(n))) begin
        x_d[n*W +: W] = gpu_din[W-1:0];
        y_d[n*W +: W] = gpu_din[2*W-1:W];
        upd_d[n]      = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      upd_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_ch_q  <= '0;
      s1_x_q   <= '0;
      s1_y_q   <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      upd_q    <= upd_d;
      s1_vld_q <= s1_vld_d;
      s1_ch_q  <= s1_ch_d;
      s1_x_q   <= s1_x_d;
      s1_y_q   <= s1_y_d;
    end
  end

  assign data_x = x_q;
  assign data_y = y_q;
  assign upd    = upd_q;
  assign busy   = s1_vld_q;

endmodule

// File: tb/tb_xy_datamux_pipe.sv
module tb_xy_datamux_pipe;
  localparam int unsigned W   = 16;
  localparam int unsigned NCH = 3;
  localparam int unsigned CW  = 2;

  logic             sys_clk = 1'b0;
  logic             reset;
  logic [2*W-1:0]   gpu_din;
  logic             gpu_wr;
  logic [CW-1:0]    gpu_ch;
  logic             addq_req;
  logic [CW-1:0]    addq_ch;
  logic [W-1:0]     addq_x, addq_y;
  logic             ack0, ack1, busy0, busy1;
  logic [NCH*W-1:0] dx0, dy0, dx1, dy1;
  logic [NCH-1:0]   upd0, upd1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  xy_datamux_pipe #(.W(W), .NCH(NCH), .SAT(1'b0)) u_wrap (
    .sys_clk(sys_clk), .reset(reset), .gpu_din(gpu_din), .gpu_wr(gpu_wr), .gpu_ch(gpu_ch),
    .addq_req(addq_req), .addq_ch(addq_ch), .addq_x(addq_x), .addq_y(addq_y),
    .addq_ack(ack0), .data_x(dx0), .data_y(dy0), .upd(upd0), .busy(busy0)
  );

  xy_datamux_pipe #(.W(W), .NCH(NCH), .SAT(1'b1)) u_sat (
    .sys_clk(sys_clk), .reset(reset), .gpu_din(gpu_din), .gpu_wr(gpu_wr), .gpu_ch(gpu_ch),
    .addq_req(addq_req), .addq_ch(addq_ch), .addq_x(addq_x), .addq_y(addq_y),
    .addq_ack(ack1), .data_x(dx1), .data_y(dy1), .upd(upd1), .busy(busy1)
  );

  // Reference model: per-mode register arrays plus one pending increment.
  logic [W-1:0]   mx [2][NCH];
  logic [W-1:0]   my [2][NCH];
  logic [NCH-1:0] m_upd;
  bit             p_vld;
  int             p_ch;
  logic [W-1:0]   p_x, p_y;

  function automatic logic [W-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input bit sat);
    int s;
    int lim;
    lim = 1 << (W - 1);
    s   = int'($signed(a)) + int'($signed(b));
    if (sat) begin
      if (s > lim - 1) s = lim - 1;
      if (s < -lim) s = -lim;
    end
    return W'(s);
  endfunction

  function automatic bit exp_ack();
    return addq_req && !gpu_wr && !reset && (int'(addq_ch) < NCH);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit a;
    a = exp_ack();
    if (reset) begin
      for (int n = 0; n < NCH; n++) begin
        for (int s = 0; s < 2; s++) begin
          mx[s][n] = '0;
          my[s][n] = '0;
        end
      end
      m_upd = '0;
      p_vld = 1'b0;
    end else begin
      m_upd = '0;
      if (p_vld) begin
        for (int s = 0; s < 2; s++) begin
          mx[s][p_ch] = ref_add(mx[s][p_ch], p_x, s[0]);
          my[s][p_ch] = ref_add(my[s][p_ch], p_y, s[0]);
        end
        m_upd[p_ch] = 1'b1;
      end
      if (gpu_wr && int'(gpu_ch) < NCH) begin
        for (int s = 0; s < 2; s++) begin
          mx[s][gpu_ch] = gpu_din[W-1:0];
          my[s][gpu_ch] = gpu_din[2*W-1:W];
        end
        m_upd[gpu_ch] = 1'b1;
      end
      p_vld = a;
      p_ch  = int'(addq_ch);
      p_x   = addq_x;
      p_y   = addq_y;
    end
  endtask

  task automatic cycle();
    bit a;
    logic [NCH*W-1:0] ex0, ey0, ex1, ey1;
    #2;
    a = exp_ack();
    chk("ack_wrap", ack0, a);
    chk("ack_sat", ack1, a);
    @(posedge sys_clk);
    model_edge();
    #1;
    for (int n = 0; n < NCH; n++) begin
      ex0[n*W +: W] = mx[0][n];
      ey0[n*W +: W] = my[0][n];
      ex1[n*W +: W] = mx[1][n];
      ey1[n*W +: W] = my[1][n];
    end
    chk("data_x_wrap", dx0, ex0);
    chk("data_y_wrap", dy0, ey0);
    chk("data_x_sat", dx1, ex1);
    chk("data_y_sat", dy1, ey1);
    chk("upd_wrap", upd0, m_upd);
    chk("upd_sat", upd1, m_upd);
    chk("busy_wrap", busy0, p_vld);
    chk("busy_sat", busy1, p_vld);
  endtask

  task automatic drive(input bit wr, input int gch, input logic [31:0] din, input bit req,
                       input int ach, input int ax, input int ay);
    gpu_wr   = wr;
    gpu_ch   = CW'(gch);
    gpu_din  = din;
    addq_req = req;
    addq_ch  = CW'(ach);
    addq_x   = W'(ax);
    addq_y   = W'(ay);
  endtask

  task automatic idle();
    drive(1'b0, 0, 32'h0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    p_vld = 1'b0;
    p_ch  = 0;
    p_x   = '0;
    p_y   = '0;
    m_upd = '0;
    reset = 1'b1;
    idle();
    cycle();
    cycle();
    chk("reset_busy", busy0, 1'b0);
    chk("reset_x", dx0, '0);
    reset = 1'b0;

    // GPU load of channel 1
    drive(1'b1, 1, 32'h0030_0010, 1'b0, 0, 0, 0);
    cycle();
    chk("gpu_x1", dx0[W +: W], 16'h0010);
    chk("gpu_y1", dy0[W +: W], 16'h0030);
    chk("gpu_upd", upd0, 3'b010);
    chk("gpu_x0", dx0[0 +: W], 16'h0000);
    idle();
    cycle();

    // Single increment: busy for one cycle, result one edge after acceptance
    drive(1'b1, 0, 32'h0000_0005, 1'b0, 0, 0, 0);
    cycle();
    drive(1'b0, 0, 32'h0, 1'b1, 0, 3, 0);
    cycle();
    chk("addq_busy", busy0, 1'b1);
    idle();
    cycle();
    chk("addq_x", dx0[0 +: W], 16'h0008);
    chk("addq_upd", upd0, 3'b001);
    chk("addq_busy_end", busy0, 1'b0);

    // Back-to-back increments to one channel
    drive(1'b1, 0, 32'h0, 1'b0, 0, 0, 0);
    cycle();
    drive(1'b0, 0, 32'h0, 1'b1, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle();
    idle();
    cycle();
    chk("b2b_x", dx0[0 +: W], 16'h0003);

    // Wrap versus saturate
    drive(1'b1, 0, 32'h0000_7FFE, 1'b0, 0, 0, 0);
    cycle();
    drive(1'b0, 0, 32'h0, 1'b1, 0, 4, 0);
    cycle();
    idle();
    cycle();
    chk("wrap_pos", dx0[0 +: W], 16'h8002);
    chk("sat_pos", dx1[0 +: W], 16'h7FFF);
    drive(1'b1, 0, 32'h0000_8001, 1'b0, 0, 0, 0);
    cycle();
    drive(1'b0, 0, 32'h0, 1'b1, 0, -4, 0);
    cycle();
    idle();
    cycle();
    chk("wrap_neg", dx0[0 +: W], 16'h7FFD);
    chk("sat_neg", dx1[0 +: W], 16'h8000);

    // GPU write collides with writeback: same channel, then other channel
    drive(1'b0, 0, 32'h0, 1'b1, 0, 5, 7);
    cycle();
    drive(1'b1, 0, 32'h0000_0100, 1'b0, 0, 0, 0);
    cycle();
    chk("coll_x", dx0[0 +: W], 16'h0100);
    chk("coll_y", dy0[0 +: W], 16'h0000);
    chk("coll_upd", upd0, 3'b001);
    drive(1'b0, 0, 32'h0, 1'b1, 0, 5, 0);
    cycle();
    drive(1'b1, 1, 32'h0002_0001, 1'b0, 0, 0, 0);
    cycle();
    chk("both_upd", upd0, 3'b011);
    chk("both_x0", dx0[0 +: W], 16'h0105);
    idle();
    cycle();

    // Reset right after acceptance discards the increment; GPU ignored in reset
    drive(1'b0, 0, 32'h0, 1'b1, 0, 1, 0);
    cycle();
    reset = 1'b1;
    drive(1'b1, 2, 32'h1234_5678, 1'b1, 1, 1, 1);
    cycle();
    chk("rst_mid_busy", busy0, 1'b0);
    chk("rst_mid_x", dx0, '0);
    reset = 1'b0;
    idle();
    cycle();
    chk("rst_mid_upd", upd0, 3'b000);

    // Out-of-range channel codes
    drive(1'b1, 3, 32'hFFFF_FFFF, 1'b1, 3, 1, 1);
    cycle();
    drive(1'b0, 0, 32'h0, 1'b1, 3, 1, 1);
    cycle();
    idle();
    cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive(($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), $urandom(),
            ($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535))
                                        : int'($urandom_range(0, 8)) - 4,
            int'($urandom_range(0, 65535)));
      cycle();
    end
    reset = 1'b0;
    idle();
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
